// File: rtl/axis_video_frame_ingress.sv
// AXI4-Stream video ingress for the Sobel pipeline.
// Takes one frame from the stream, repairs short and long lines, and writes exactly rows*cols
// pixels into the downstream HLS FIFO. Pixel data passes straight through with no pipeline
// stage, so an accepted beat is written in the cycle of its handshake.
module axis_video_frame_ingress #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_ROWS = 128,
  parameter int unsigned MAX_COLS = 128,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [7:0]        rows,
  input  logic [7:0]        cols,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] out_din,
  output logic              out_write,
  input  logic              out_full_n,
  output logic              stall_in,
  output logic              stall_out,
  output logic [CNT_W-1:0]  early_eol_cnt,
  output logic [CNT_W-1:0]  late_eol_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSof,
    StRow,
    StFlush,
    StPad,
    StDone
  } state_e;

  // Frame dimensions are carried on 8-bit ports; the limits are narrowed to match.
  localparam logic [7:0] MaxRows = 8'(MAX_ROWS);
  localparam logic [7:0] MaxCols = 8'(MAX_COLS);

  state_e            state_q, state_d;
  logic [7:0]        rows_q, rows_d;
  logic [7:0]        cols_q, cols_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic [CNT_W-1:0]  early_q, early_d;
  logic [CNT_W-1:0]  late_q, late_d;

  logic [7:0] rows_lim, cols_lim;
  logic [7:0] row_inc, col_inc;
  logic       beat_acc;
  logic       data_beat;
  logic       col_last;
  logic       end_row;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Out-of-range dimensions are clamped so the frame still terminates.
  assign rows_lim = (rows > MaxRows) ? MaxRows : rows;
  assign cols_lim = (cols > MaxCols) ? MaxCols : cols;

  assign row_inc  = row_q + 8'd1;
  assign col_inc  = col_q + 8'd1;
  assign beat_acc = s_axis_tvalid & s_axis_tready;
  // The SOF beat is the first pixel; in ROW every accepted beat is a pixel.
  assign data_beat = beat_acc & ((state_q == StRow) | ((state_q == StWaitSof) & s_axis_tuser));
  assign col_last  = (col_q == cols_q - 8'd1);

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame geometry, position and error counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rows_q  <= '0;
      cols_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      early_q <= '0;
      late_q  <= '0;
    end else begin
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      row_q   <= row_d;
      col_q   <= col_d;
      early_q <= early_d;
      late_q  <= late_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    early_d = early_q;
    late_d  = late_q;
    end_row = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          rows_d  = rows_lim;
          cols_d  = cols_lim;
          row_d   = '0;
          col_d   = '0;
          early_d = '0;
          late_d  = '0;
          state_d = ((rows_lim == 8'd0) || (cols_lim == 8'd0)) ? StDone : StWaitSof;
        end
      end
      StWaitSof, StRow: begin
        if (data_beat) begin
          if (col_last) begin
            if (s_axis_tlast) begin
              end_row = 1'b1;
            end else begin
              late_d  = sat_inc(late_q);
              state_d = StFlush;
            end
          end else begin
            col_d   = col_inc;
            state_d = StRow;
            if (s_axis_tlast) begin
              early_d = sat_inc(early_q);
              state_d = StPad;
            end
          end
        end
      end
      StFlush: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          end_row = 1'b1;
        end
      end
      StPad: begin
        if (out_full_n) begin
          if (col_inc == cols_q) begin
            end_row = 1'b1;
          end else begin
            col_d = col_inc;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Later rows need no SOF, so a finished row always resumes in ROW.
    if (end_row) begin
      row_d   = row_inc;
      col_d   = '0;
      state_d = (row_inc == rows_q) ? StDone : StRow;
    end
  end

  // Handshake, FIFO write and stall outputs decoded from the current state.
  always_comb begin
    s_axis_tready = 1'b0;
    out_write     = 1'b0;
    out_din       = '0;
    stall_in      = 1'b0;
    stall_out     = 1'b0;

    unique case (state_q)
      StWaitSof: begin
        s_axis_tready = out_full_n;
        out_write     = s_axis_tvalid & out_full_n & s_axis_tuser;
        out_din       = out_write ? s_axis_tdata : '0;
        stall_in      = ~s_axis_tvalid & out_full_n;
        stall_out     = ~out_full_n;
      end
      StRow: begin
        s_axis_tready = out_full_n;
        out_write     = s_axis_tvalid & out_full_n;
        out_din       = out_write ? s_axis_tdata : '0;
        stall_in      = ~s_axis_tvalid & out_full_n;
        stall_out     = ~out_full_n;
      end
      StFlush: begin
        s_axis_tready = 1'b1;
      end
      StPad: begin
        out_write = out_full_n;
        stall_out = ~out_full_n;
      end
      default: begin
      end
    endcase
  end

  assign ap_idle       = (state_q == StIdle);
  assign ap_done       = (state_q == StDone);
  assign early_eol_cnt = early_q;
  assign late_eol_cnt  = late_q;

endmodule

// File: tb/tb_axis_video_frame_ingress.sv
// Randomised scoreboard bench for axis_video_frame_ingress.
// A line-level reference model turns each generated beat stream into the expected pixel
// sequence and error counts; a monitor pops pixels as the DUT writes them.
module tb_axis_video_frame_ingress;

  localparam int DW     = 32;
  localparam int CW     = 2;
  localparam int CMAX   = 3;
  localparam int BUDGET = 2000;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_done, ap_idle;
  logic [7:0]    rows, cols;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [DW-1:0] out_din;
  logic          out_write, out_full_n;
  logic          stall_in, stall_out;
  logic [CW-1:0] early_eol_cnt, late_eol_cnt;

  always #5 ap_clk = ~ap_clk;

  axis_video_frame_ingress #(
    .DATA_W  (DW),
    .MAX_ROWS(128),
    .MAX_COLS(128),
    .CNT_W   (CW)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .rows         (rows),
    .cols         (cols),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .out_din      (out_din),
    .out_write    (out_write),
    .out_full_n   (out_full_n),
    .stall_in     (stall_in),
    .stall_out    (stall_out),
    .early_eol_cnt(early_eol_cnt),
    .late_eol_cnt (late_eol_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_early = 0;
  int            exp_late  = 0;
  logic          exp_sin   = 1'b0;
  logic          exp_sout  = 1'b0;
  logic          prev_done = 1'b0;

  // Beat stream of the current frame and its classification by the model:
  // 0 ignored, 1 pixel, 2 pixel ending a short line, 3 flushed.
  logic [DW-1:0] b_data[$];
  logic          b_user[$];
  logic          b_last[$];
  int            b_cls[$];
  int            b_pad[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctrl"}, 64'({ap_idle, ap_done, s_axis_tready, out_write, stall_in, stall_out}),
          64'(6'b100000));
    check({tag, "_din"}, 64'(out_din), 64'(0));
    check({tag, "_cnt"}, 64'({early_eol_cnt, late_eol_cnt}), 64'(0));
  endtask

  // Scoreboard monitor: pixels, stall flags and end-of-frame status.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        check("stall_in", 64'(stall_in), 64'(exp_sin));
        check("stall_out", 64'(stall_out), 64'(exp_sout));
        check("stall_excl", 64'(stall_in & stall_out), 64'(0));
        if (out_write) begin
          check("write_while_full", 64'(out_full_n), 64'(1));
          if (exp_q.size() == 0) begin
            check("extra_write", 64'(out_din), 64'(-1));
          end else begin
            check("pixel", 64'(out_din), 64'(exp_q.pop_front()));
          end
        end
        if (ap_done) begin
          check("done_pulse_len", 64'(prev_done), 64'(0));
          check("early_cnt", 64'(early_eol_cnt), 64'(exp_early));
          check("late_cnt", 64'(late_eol_cnt), 64'(exp_late));
          check("missing_writes", 64'(exp_q.size()), 64'(0));
        end
      end
      prev_done = ap_done;
    end
  end

  task automatic new_frame();
    b_data.delete();
    b_user.delete();
    b_last.delete();
  endtask

  task automatic add_junk(input int n);
    for (int k = 0; k < n; k++) begin
      b_data.push_back($urandom | 32'h1);
      b_user.push_back(1'b0);
      b_last.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic add_row(input int len, input bit sof, input bit rand_user);
    for (int k = 0; k < len; k++) begin
      b_data.push_back($urandom | 32'h1);
      if (sof && k == 0) b_user.push_back(1'b1);
      else b_user.push_back(rand_user && ($urandom_range(0, 4) == 0));
      b_last.push_back(k == len - 1);
    end
  endtask

  // Line-level reference: skip to SOF, then cut the stream into lines of exactly c pixels.
  task automatic build_model(input int r, input int c);
    int i  = 0;
    int sz = b_data.size();
    int col;
    b_cls.delete();
    b_pad.delete();
    for (int k = 0; k < sz; k++) begin
      b_cls.push_back(0);
      b_pad.push_back(0);
    end
    exp_early = 0;
    exp_late  = 0;
    if (r == 0 || c == 0) return;
    while (i < sz && !b_user[i]) i++;
    for (int row = 0; row < r; row++) begin
      col = 0;
      while (1) begin
        if (i >= sz) return;
        exp_q.push_back(b_data[i]);
        b_cls[i] = 1;
        col++;
        if (col == c) begin
          if (!b_last[i]) begin
            exp_late = (exp_late < CMAX) ? exp_late + 1 : CMAX;
            i++;
            while (i < sz) begin
              b_cls[i] = 3;
              if (b_last[i]) begin
                i++;
                break;
              end
              i++;
            end
          end else begin
            i++;
          end
          break;
        end
        if (b_last[i]) begin
          b_cls[i] = 2;
          b_pad[i] = c - col;
          for (int p = 0; p < c - col; p++) exp_q.push_back('0);
          exp_early = (exp_early < CMAX) ? exp_early + 1 : CMAX;
          i++;
          break;
        end
        i++;
      end
    end
  endtask

  // full_mode: 0 always ready, 1 toggling, 2 random.
  task automatic run_frame(input int r, input int c, input int full_mode, input bit gaps,
                           input bit rnd_start, input int abort_at);
    int  i = 0;
    int  pad_left = 0;
    int  writes_left;
    int  cyc = 0;
    int  sz;
    bit  valid, full, in_pad, in_flush, elig, fin;
    build_model(r, c);
    sz = b_data.size();
    writes_left = (r == 0 || c == 0) ? 0 : r * c;
    @(posedge ap_clk);
    #1;
    rows     = 8'(r);
    cols     = 8'(c);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    while (1) begin
      fin = (writes_left == 0) && (pad_left == 0) && !(i < sz && b_cls[i] == 3);
      if (fin) break;
      if (cyc >= BUDGET) begin
        check("frame_timeout", 64'(cyc), 64'(0));
        break;
      end
      if (abort_at > 0 && cyc == abort_at) begin
        #2 ap_rst_n = 1'b0;
        #1 check_reset("mid_reset");
        exp_q.delete();
        exp_sin       = 1'b0;
        exp_sout      = 1'b0;
        s_axis_tvalid = 1'b0;
        ap_start      = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        return;
      end
      case (full_mode)
        0:       full = 1'b1;
        1:       full = (cyc % 2 == 0);
        default: full = 1'($urandom_range(0, 1));
      endcase
      valid = (i < sz) && (!gaps || $urandom_range(0, 2) != 0);
      out_full_n    = full;
      s_axis_tvalid = valid;
      s_axis_tdata  = valid ? b_data[i] : $urandom;
      s_axis_tuser  = valid ? b_user[i] : 1'($urandom_range(0, 1));
      s_axis_tlast  = valid ? b_last[i] : 1'($urandom_range(0, 1));
      ap_start      = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      in_pad   = pad_left > 0;
      in_flush = !in_pad && i < sz && b_cls[i] == 3;
      elig     = writes_left > 0 && !in_pad && !in_flush;
      exp_sin  = elig && !valid && full;
      exp_sout = (elig || in_pad) && !full;
      @(negedge ap_clk);
      if (in_pad) begin
        if (full) begin
          pad_left--;
          writes_left--;
        end
      end else if (valid && (in_flush || (elig && full))) begin
        if (b_cls[i] == 1) writes_left--;
        if (b_cls[i] == 2) begin
          writes_left--;
          pad_left = b_pad[i];
        end
        i++;
      end
      cyc++;
      @(posedge ap_clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    ap_start      = 1'b0;
    exp_sin       = 1'b0;
    exp_sout      = 1'b0;
    @(negedge ap_clk);
    check("ap_done", 64'(ap_done), 64'(1));
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check("done_once", 64'(ap_done), 64'(0));
    check("idle_after", 64'(ap_idle), 64'(1));
    check("early_hold", 64'(early_eol_cnt), 64'(exp_early));
    check("late_hold", 64'(late_eol_cnt), 64'(exp_late));
  endtask

  task automatic random_frame();
    int r = $urandom_range(1, 6);
    int c = $urandom_range(1, 6);
    int len;
    int kind;
    new_frame();
    add_junk($urandom_range(0, 3));
    for (int k = 0; k < r; k++) begin
      kind = $urandom_range(0, 99);
      if (kind < 15 && c > 1) len = $urandom_range(1, c - 1);
      else if (kind < 30) len = c + $urandom_range(1, 3);
      else len = c;
      add_row(len, k == 0, 1'b1);
    end
    run_frame(r, c, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b1, 0);
  endtask

  initial begin
    ap_rst_n      = 1'b0;
    ap_start      = 1'b0;
    rows          = '0;
    cols          = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    out_full_n    = 1'b1;
    #12;
    check_reset("reset");
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;

    // Clean 4x4 frame.
    new_frame();
    for (int k = 0; k < 4; k++) add_row(4, k == 0, 1'b0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 0);

    // Junk before SOF.
    new_frame();
    add_junk(3);
    for (int k = 0; k < 4; k++) add_row(4, k == 0, 1'b0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 0);

    // Short row 1.
    new_frame();
    add_row(4, 1'b1, 1'b0);
    add_row(2, 1'b0, 1'b0);
    add_row(4, 1'b0, 1'b0);
    add_row(4, 1'b0, 1'b0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 0);

    // Long row 0.
    new_frame();
    add_row(6, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add_row(4, 1'b0, 1'b0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 0);

    // Toggling FIFO and input gaps with both repairs.
    new_frame();
    add_junk(1);
    add_row(4, 1'b1, 1'b0);
    add_row(1, 1'b0, 1'b0);
    add_row(7, 1'b0, 1'b0);
    add_row(4, 1'b0, 1'b0);
    run_frame(4, 4, 1, 1'b1, 1'b0, 0);

    // Reset in row 2, then a fresh frame.
    new_frame();
    for (int k = 0; k < 4; k++) add_row(4, k == 0, 1'b0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 10);
    new_frame();
    for (int k = 0; k < 4; k++) add_row(4, k == 0, 1'b0);
    run_frame(4, 4, 0, 1'b0, 1'b0, 0);

    // Degenerate dimensions go straight to done.
    new_frame();
    run_frame(0, 4, 0, 1'b0, 1'b0, 0);
    new_frame();
    run_frame(3, 0, 0, 1'b0, 1'b0, 0);

    // Single-column frame, including a long line on the SOF beat.
    new_frame();
    add_row(3, 1'b1, 1'b0);
    add_row(1, 1'b0, 1'b0);
    add_row(1, 1'b0, 1'b0);
    run_frame(3, 1, 2, 1'b1, 1'b0, 0);

    // Counter saturation.
    new_frame();
    for (int k = 0; k < 5; k++) add_row(1, k == 0, 1'b0);
    run_frame(5, 4, 0, 1'b0, 1'b0, 0);
    new_frame();
    for (int k = 0; k < 5; k++) add_row(6, k == 0, 1'b0);
    run_frame(5, 4, 2, 1'b1, 1'b0, 0);

    for (int n = 0; n < 25; n++) random_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
